// File: rtl/led_step_ctrl.sv
// led_step_ctrl: button synchronise/debounce plus step-rate generator that
// drives the 6-LED rotator. Pause toggles stepping; speed cycles 1x..8x.
module led_step_ctrl #(
    parameter int unsigned DB_CYCLES   = 540_000,
    parameter int unsigned BASE_PERIOD = 13_500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       btn_pause_n,
    input  logic       btn_speed_n,
    output logic       step,
    output logic       paused,
    output logic [1:0] speed
);

    localparam int unsigned DB_W  = $clog2(DB_CYCLES);
    localparam int unsigned CNT_W = 24;
    localparam int unsigned PER_W = CNT_W + 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [PER_W-1:0] BASE    = PER_W'(BASE_PERIOD);

    // Bit 0 is the pause button, bit 1 the speed button.
    logic [1:0]            raw;
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            stable;
    logic [1:0]            stable_q;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic [1:0]            press;
    logic                  pause_ev;
    logic                  speed_ev;

    logic [CNT_W-1:0]      cnt;
    logic [PER_W-1:0]      period;
    logic                  tc;

    assign raw = {btn_speed_n, btn_pause_n};

    // Two-flop synchroniser; idle level is released (1).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: flip the stable level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stable   <= 2'b11;
            stable_q <= 2'b11;
            db_cnt   <= '0;
        end else begin
            stable_q <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press = stable level falling 1->0; releases are ignored.
    assign press    = stable_q & ~stable;
    assign pause_ev = press[0];
    assign speed_ev = press[1];

    // Current period and terminal-count detect; paused never reaches terminal count.
    always_comb begin
        period = BASE >> speed;
        tc     = !paused && (cnt == CNT_W'(period - PER_W'(1)));
    end

    // Period counter, step pulse, pause and speed state; either event cancels a coincident step.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt    <= '0;
            step   <= 1'b0;
            paused <= 1'b0;
            speed  <= 2'd0;
        end else begin
            step   <= tc & ~pause_ev & ~speed_ev;
            paused <= paused ^ pause_ev;
            if (speed_ev) begin
                speed <= speed + 2'd1;
                cnt   <= '0;
            end else if (!paused) begin
                cnt <= tc ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with DB_CYCLES=4, BASE_PERIOD=16.
// Edge numbering: edge 1 is the first rising edge after reset release; a button
// value set for edge i is applied just after edge i-1 and sampled at edge i.
// Outputs are sampled 1 ns after each edge.
module tb_led_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause_n = 1'b1;
    logic       speed_n = 1'b1;
    logic       step;
    logic       paused;
    logic [1:0] speed;

    int checks   = 0;
    int failures = 0;

    led_step_ctrl #(
        .DB_CYCLES  (4),
        .BASE_PERIOD(16)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .btn_pause_n(pause_n),
        .btn_speed_n(speed_n),
        .step       (step),
        .paused     (paused),
        .speed      (speed)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        pause_n = 1'b1;
        speed_n = 1'b1;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
    endtask

    task automatic test_reset;
        logic exp_step;
        pause_n = 1'b1;
        speed_n = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({step, paused, speed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async got=%b%b%0d exp=000", step, paused, speed);
        end
        tick();
        tick();
        checks++;
        if ({step, paused, speed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held got=%b%b%0d exp=000", step, paused, speed);
        end
        rst = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            exp_step = (i == 16) || (i == 32) || (i == 48);
            checks++;
            if (step !== exp_step || paused !== 1'b0 || speed !== 2'd0) begin
                failures++;
                $display("FAIL free_run edge=%0d step=%b paused=%b speed=%0d exp_step=%b",
                         i, step, paused, speed, exp_step);
            end
        end
    endtask

    task automatic test_bounce;
        logic exp_step;
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            pause_n = !((i >= 3 && i <= 5) || (i >= 7 && i <= 9));
            tick();
            exp_step = (i == 16) || (i == 32) || (i == 48);
            checks++;
            if (step !== exp_step || paused !== 1'b0) begin
                failures++;
                $display("FAIL bounce edge=%0d step=%b paused=%b exp_step=%b exp_paused=0",
                         i, step, paused, exp_step);
            end
        end
        pause_n = 1'b1;
    endtask

    task automatic test_pause_resume;
        logic exp_step;
        logic exp_paused;
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            pause_n = !((i >= 6 && i <= 17) || (i >= 30 && i <= 35));
            tick();
            exp_step   = (i == 40) || (i == 56);
            exp_paused = (i >= 12) && (i < 36);
            checks++;
            if (step !== exp_step || paused !== exp_paused) begin
                failures++;
                $display("FAIL pause_resume edge=%0d step=%b paused=%b exp_step=%b exp_paused=%b",
                         i, step, paused, exp_step, exp_paused);
            end
        end
        pause_n = 1'b1;
    endtask

    task automatic test_speed_cycle;
        logic       exp_step;
        logic [1:0] exp_speed;
        do_reset();
        for (int i = 1; i <= 90; i++) begin
            speed_n = !((i >= 2 && i <= 7) || (i >= 20 && i <= 25) ||
                        (i >= 36 && i <= 41) || (i >= 50 && i <= 55));
            tick();
            exp_step = (i == 16) || (i == 24) || (i == 30) || (i == 34) || (i == 38) ||
                       (i == 44) || (i == 46) || (i == 48) || (i == 50) || (i == 52) ||
                       (i == 54) || (i == 72) || (i == 88);
            if (i < 8)       exp_speed = 2'd0;
            else if (i < 26) exp_speed = 2'd1;
            else if (i < 42) exp_speed = 2'd2;
            else if (i < 56) exp_speed = 2'd3;
            else             exp_speed = 2'd0;
            checks++;
            if (step !== exp_step || speed !== exp_speed || paused !== 1'b0) begin
                failures++;
                $display("FAIL speed_cycle edge=%0d step=%b speed=%0d paused=%b exp_step=%b exp_speed=%0d",
                         i, step, speed, paused, exp_step, exp_speed);
            end
        end
        speed_n = 1'b1;
    endtask

    task automatic test_simultaneous;
        logic       exp_paused;
        logic [1:0] exp_speed;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            pause_n = !(i >= 10 && i <= 15);
            speed_n = !(i >= 10 && i <= 15);
            tick();
            exp_paused = (i >= 16);
            exp_speed  = (i >= 16) ? 2'd1 : 2'd0;
            checks++;
            if (step !== 1'b0 || paused !== exp_paused || speed !== exp_speed) begin
                failures++;
                $display("FAIL simultaneous edge=%0d step=%b paused=%b speed=%0d exp_step=0 exp_paused=%b exp_speed=%0d",
                         i, step, paused, speed, exp_paused, exp_speed);
            end
        end
        pause_n = 1'b1;
        speed_n = 1'b1;
    endtask

    task automatic test_mid_reset;
        logic       exp_step;
        logic       exp_paused;
        logic [1:0] exp_speed;
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            speed_n = !((i >= 2 && i <= 7) || (i >= 14 && i <= 19) || (i >= 34));
            pause_n = !(i >= 24 && i <= 29);
            tick();
            exp_step   = (i == 16) || (i == 24) || (i == 28);
            exp_paused = (i >= 30);
            if (i < 8)       exp_speed = 2'd0;
            else if (i < 20) exp_speed = 2'd1;
            else             exp_speed = 2'd2;
            checks++;
            if (step !== exp_step || paused !== exp_paused || speed !== exp_speed) begin
                failures++;
                $display("FAIL mid_reset_setup edge=%0d step=%b paused=%b speed=%0d exp_step=%b exp_paused=%b exp_speed=%0d",
                         i, step, paused, speed, exp_step, exp_paused, exp_speed);
            end
        end
        #3;
        rst     = 1'b1;
        pause_n = 1'b1;
        speed_n = 1'b1;
        #1;
        checks++;
        if ({step, paused, speed} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_async got=%b%b%0d exp=000", step, paused, speed);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            exp_step = (i == 16) || (i == 32);
            checks++;
            if (step !== exp_step || paused !== 1'b0 || speed !== 2'd0) begin
                failures++;
                $display("FAIL mid_reset_after edge=%0d step=%b paused=%b speed=%0d exp_step=%b",
                         i, step, paused, speed, exp_step);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_pause_resume();
        test_speed_cycle();
        test_simultaneous();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
